// File: rtl/load_store_unit_if.sv
// Data-memory port bundle between the load/store unit (master) and memory (slave).
// Word-addressed request/ready handshake; read data is valid in the ready cycle.
interface load_store_unit_if #(
   parameter int DATA_WIDTH = 32
);
   logic                      o_Mem_Req;
   logic                      o_Mem_Write;
   logic [DATA_WIDTH-1:0]     o_Mem_Address;
   logic [DATA_WIDTH-1:0]     o_Mem_Write_Data;
   logic [DATA_WIDTH/8-1:0]   o_Mem_Byte_Enable;
   logic                      i_Mem_Ready;
   logic [DATA_WIDTH-1:0]     i_Mem_Read_Data;

   modport master (
      output o_Mem_Req, o_Mem_Write, o_Mem_Address, o_Mem_Write_Data, o_Mem_Byte_Enable,
      input  i_Mem_Ready, i_Mem_Read_Data
   );

   modport slave (
      input  o_Mem_Req, o_Mem_Write, o_Mem_Address, o_Mem_Write_Data, o_Mem_Byte_Enable,
      output i_Mem_Ready, i_Mem_Read_Data
   );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: data-memory access stage downstream of the control unit.
// Issues one word-addressed access per request, builds byte enables and
// lane-replicated store data, and formats load results for write-back.
// Optional feature macro: LSU_MISALIGNED_TRAP_EN
//   defined   -> misaligned half/word requests finish with o_Misaligned, no access
//   undefined -> offending low address bits are cleared and the access proceeds
// Only DATA_WIDTH = 32 is supported.
module load_store_unit #(
   parameter int DATA_WIDTH   = 32,
   parameter int LS_SEL_WIDTH = 3
) (
   input  logic                    i_Clock,
   input  logic                    i_Reset,
   input  logic                    i_Start,
   input  logic [LS_SEL_WIDTH:0]   i_Load_Store_Type,
   input  logic                    i_Mem_Write_Enable,
   input  logic [DATA_WIDTH-1:0]   i_Address,
   input  logic [DATA_WIDTH-1:0]   i_Store_Data,
   load_store_unit_if.master       mem,
   output logic [DATA_WIDTH-1:0]   o_Load_Data,
   output logic                    o_Done,
   output logic                    o_Busy,
   output logic                    o_Misaligned
);

   // Load/store type codes shared with the control unit
   localparam logic [LS_SEL_WIDTH:0] LS_TYPE_NONE     = 'd0;
   localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_B   = 'd1;
   localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_H   = 'd2;
   localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_W   = 'd3;
   localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_BU  = 'd4;
   localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_HU  = 'd5;
   localparam logic [LS_SEL_WIDTH:0] LS_TYPE_STORE_B  = 'd6;
   localparam logic [LS_SEL_WIDTH:0] LS_TYPE_STORE_H  = 'd7;
   localparam logic [LS_SEL_WIDTH:0] LS_TYPE_STORE_W  = 'd8;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t              r_state;
   logic                r_mem_req;
   logic                r_mem_write;
   logic [31:0]         r_mem_address;
   logic [31:0]         r_mem_write_data;
   logic [3:0]          r_mem_byte_enable;
   logic [1:0]          r_offset;
   logic [1:0]          r_size;
   logic                r_unsigned;
   logic [31:0]         r_load_data;
   logic                r_done;
   logic                r_busy;
   logic                r_misaligned;

   logic                w_recognised;
   logic                w_is_store;
   logic [1:0]          w_size;
   logic                w_unsigned;
   logic                w_valid;
   logic                w_misaligned;
   logic [1:0]          w_offset;
   logic [3:0]          w_byte_enable;
   logic [31:0]         w_write_data;
   logic [7:0]          w_lane_byte;
   logic [15:0]         w_lane_half;
   logic [31:0]         w_load_fmt;

   // Decode the request type; a store flag that disagrees with the type kills the request
   always_comb begin
      w_recognised = 1'b1;
      w_is_store   = 1'b0;
      w_size       = SIZE_WORD;
      w_unsigned   = 1'b0;
      case (i_Load_Store_Type)
         LS_TYPE_LOAD_B:  w_size = SIZE_BYTE;
         LS_TYPE_LOAD_H:  w_size = SIZE_HALF;
         LS_TYPE_LOAD_W:  w_size = SIZE_WORD;
         LS_TYPE_LOAD_BU: begin w_size = SIZE_BYTE; w_unsigned = 1'b1; end
         LS_TYPE_LOAD_HU: begin w_size = SIZE_HALF; w_unsigned = 1'b1; end
         LS_TYPE_STORE_B: begin w_size = SIZE_BYTE; w_is_store = 1'b1; end
         LS_TYPE_STORE_H: begin w_size = SIZE_HALF; w_is_store = 1'b1; end
         LS_TYPE_STORE_W: begin w_size = SIZE_WORD; w_is_store = 1'b1; end
         default:         w_recognised = 1'b0;
      endcase
      w_valid = w_recognised && (w_is_store == i_Mem_Write_Enable);
   end

   // Lane offset, enables and replicated store data for the incoming request
   always_comb begin
      w_offset      = 2'b00;
      w_byte_enable = 4'b1111;
      w_write_data  = i_Store_Data;
      case (w_size)
         SIZE_BYTE: begin
            w_offset      = i_Address[1:0];
            w_byte_enable = 4'b0001 << w_offset;
            w_write_data  = {4{i_Store_Data[7:0]}};
         end
         SIZE_HALF: begin
            w_offset      = {i_Address[1], 1'b0};
            w_byte_enable = 4'b0011 << w_offset;
            w_write_data  = {2{i_Store_Data[15:0]}};
         end
         default: begin
            w_offset      = 2'b00;
            w_byte_enable = 4'b1111;
            w_write_data  = i_Store_Data;
         end
      endcase
`ifdef LSU_MISALIGNED_TRAP_EN
      w_misaligned = w_valid &&
                     (((w_size == SIZE_HALF) && i_Address[0]) ||
                      ((w_size == SIZE_WORD) && (i_Address[1:0] != 2'b00)));
`else
      // Low address bits are simply dropped through w_offset above
      w_misaligned = 1'b0;
`endif
   end

   // Extract the addressed lane from the returned word and extend it
   always_comb begin
      w_lane_byte = mem.i_Mem_Read_Data[{r_offset, 3'b000} +: 8];
      w_lane_half = mem.i_Mem_Read_Data[{r_offset[1], 4'b0000} +: 16];
      case (r_size)
         SIZE_BYTE: w_load_fmt = r_unsigned ? {24'd0, w_lane_byte}
                                            : {{24{w_lane_byte[7]}}, w_lane_byte};
         SIZE_HALF: w_load_fmt = r_unsigned ? {16'd0, w_lane_half}
                                            : {{16{w_lane_half[15]}}, w_lane_half};
         default:   w_load_fmt = mem.i_Mem_Read_Data;
      endcase
   end

   // Control FSM with registered bus, status and load-result outputs
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_state           <= IDLE;
         r_mem_req         <= 1'b0;
         r_mem_write       <= 1'b0;
         r_mem_address     <= '0;
         r_mem_write_data  <= '0;
         r_mem_byte_enable <= '0;
         r_offset          <= '0;
         r_size            <= '0;
         r_unsigned        <= 1'b0;
         r_load_data       <= '0;
         r_done            <= 1'b0;
         r_busy            <= 1'b0;
         r_misaligned      <= 1'b0;
      end else begin
         r_done       <= 1'b0;
         r_misaligned <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_Start) begin
                  r_busy <= 1'b1;
                  if (!w_valid || w_misaligned) begin
                     // Nothing to access: finish immediately, flagging any fault
                     r_state      <= DONE;
                     r_done       <= 1'b1;
                     r_misaligned <= w_misaligned;
                  end else begin
                     r_state           <= ACCESS;
                     r_mem_req         <= 1'b1;
                     r_mem_write       <= w_is_store;
                     r_mem_address     <= {i_Address[31:2], 2'b00};
                     r_mem_write_data  <= w_write_data;
                     r_mem_byte_enable <= w_byte_enable;
                     r_offset          <= w_offset;
                     r_size            <= w_size;
                     r_unsigned        <= w_unsigned;
                  end
               end
            end
            ACCESS: begin
               if (mem.i_Mem_Ready) begin
                  if (!r_mem_write) begin
                     r_load_data <= w_load_fmt;
                  end
                  r_mem_req   <= 1'b0;
                  r_mem_write <= 1'b0;
                  r_done      <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy    <= 1'b0;
               r_mem_req <= 1'b0;
               r_state   <= IDLE;
            end
         endcase
      end
   end

   assign mem.o_Mem_Req         = r_mem_req;
   assign mem.o_Mem_Write       = r_mem_write;
   assign mem.o_Mem_Address     = r_mem_address;
   assign mem.o_Mem_Write_Data  = r_mem_write_data;
   assign mem.o_Mem_Byte_Enable = r_mem_byte_enable;
   assign o_Load_Data           = r_load_data;
   assign o_Done                = r_done;
   assign o_Busy                = r_busy;
   assign o_Misaligned          = r_misaligned;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage of the CPU, directly downstream of the control unit. It consumes the decoded load/store type and memory write enable, plus the ALU-computed effective address and rs2 store data. It runs a word-addressed request/ready transaction on the data-memory port, generating byte enables and lane-replicated store data. For loads, it returns a sign- or zero-extended result for the REG_WRITE_DMEM write-back path.

## Interface
- Parameters:
- DATA_WIDTH, 32, data and address width; only 32 is supported.
- Ports:
- i_Clock  input  1  the single clock for the block; all state updates on its rising edge.
- i_Reset  input  1  synchronous, active-high reset.
- i_Start  input  1  one-cycle request strobe; sampled only in IDLE.
- i_Load_Store_Type  input  LS_SEL_WIDTH+1  LS_TYPE_* code from the control unit.
- i_Mem_Write_Enable  input  1  control unit store flag; must agree with a LS_TYPE_STORE_* code.
- i_Address  input  32  effective byte address from the ALU.
- i_Store_Data  input  32  rs2 value.
- o_Mem_Req  output  1  data-memory request, held until accepted.
- o_Mem_Write  output  1  1 = write, 0 = read; valid while o_Mem_Req is high.
- o_Mem_Address  output  32  word address: {i_Address[31:2], 2'b00}.
- o_Mem_Write_Data  output  32  lane-replicated store data.
- o_Mem_Byte_Enable  output  4  active byte lanes.
- i_Mem_Ready  input  1  memory accepts and completes the access this cycle; read data is valid in the same cycle.
- i_Mem_Read_Data  input  32  read word.
- o_Load_Data  output  32  formatted load result; holds until the next completed load.
- o_Done  output  1  one-cycle completion pulse.
- o_Busy  output  1  high in every state other than IDLE.
- o_Misaligned  output  1  one-cycle fault pulse, coincident with o_Done.

## Operation
- Reset: state is IDLE.
- Reset values: o_Mem_Req, o_Mem_Write, o_Done, o_Busy and o_Misaligned are 0; o_Mem_Address, o_Mem_Write_Data, o_Mem_Byte_Enable and o_Load_Data are all zero.
- States: IDLE, ACCESS, DONE.
- IDLE + i_Start, type LS_TYPE_NONE (or unrecognised code):
  - Go to DONE.
  - No memory request is issued.
- IDLE + i_Start, misaligned address:
  - A half access is misaligned when i_Address[0] is 1; a word access is misaligned when i_Address[1:0] is nonzero.
  - Go to DONE with o_Misaligned set.
  - No memory request is issued.
- IDLE + i_Start, valid and aligned:
  - Register the address, lane, type, enables and data; assert o_Mem_Req; go to ACCESS.
- Byte enables:
  - Byte: 4'b0001 << addr[1:0].
  - Half: 4'b0011 << {addr[1],1'b0}.
  - Word: 4'b1111.
  - Loads drive the same enables as stores.
- Store data: byte = {4{rs2[7:0]}}, half = {2{rs2[15:0]}}, word = rs2.
- ACCESS: o_Mem_Req and all o_Mem_* outputs hold stable until i_Mem_Ready.
- ACCESS + i_Mem_Ready:
  - For a load, register o_Load_Data from the selected lane: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
  - Drop o_Mem_Req; go to DONE.
- DONE: o_Done = 1 for one cycle, then return to IDLE.
- i_Start while o_Busy is high is ignored.
- i_Mem_Ready outside ACCESS is ignored.
- i_Mem_Write_Enable = 1 with a LS_TYPE_LOAD_* type is treated as LS_TYPE_NONE; no access is made.

## Timing
- i_Start at edge N: o_Mem_Req is high after N.
- i_Mem_Ready sampled at edge M: o_Load_Data is updated and o_Done is high after M; o_Mem_Req is low after M.
- Zero-wait memory (ready on the first ACCESS cycle): o_Done two cycles after i_Start. The minimum back-to-back issue rate is one access per three cycles.
- NONE and misaligned requests: o_Done one cycle after i_Start.
- i_Reset asserted in any state: IDLE at the next edge; o_Mem_Req is deasserted; no o_Done is produced.
- Any outstanding memory transaction is abandoned on reset; the memory must tolerate request withdrawal on reset.

## Configuration
- LSU_MISALIGNED_TRAP_EN defined:
  - Misalignment is detected and flagged as described above.
- LSU_MISALIGNED_TRAP_EN undefined:
  - o_Misaligned is tied to 0.
  - Offending low address bits are forced to zero: half uses {addr[1],1'b0}; word uses 2'b00.
  - The access then proceeds normally.

## Test plan
- Reset: assert i_Reset for 2 cycles → every output is 0 and o_Busy = 0.
- SB, address 0x1003, rs2 0xAABBCCDD, ready on the first ACCESS cycle → o_Mem_Address 0x1000, o_Mem_Byte_Enable 4'b1000, o_Mem_Write_Data 0xDDDDDDDD, o_Mem_Write 1; o_Done two cycles after i_Start.
- LB and LBU, address 0x2001, memory returns 0x0000F000 → LB gives o_Load_Data 0xFFFFFFF0; LBU gives 0x000000F0.
- LH, address 0x2002, memory returns 0x80010000, i_Mem_Ready delayed 3 cycles → o_Mem_Req and outputs stable for 3 cycles; o_Load_Data 0xFFFF8001; o_Done the cycle after ready.
- LW, address 0x3002:
  - With LSU_MISALIGNED_TRAP_EN: o_Misaligned = o_Done = 1 one cycle after i_Start; o_Mem_Req never asserted.
  - Without it: o_Mem_Address 0x3000, enables 4'b1111.
- i_Reset during ACCESS with i_Mem_Ready held low → IDLE next cycle, o_Mem_Req 0, no o_Done; a new SW issued afterwards completes normally.
